// File: rtl/mem_bist_if.sv
// Memory-side port bundle of the March C- BIST controller.
// The master drives the memory controls; the slave (memory) returns registered read data.
interface mem_bist_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MEM_WIDTH  = 16
);
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0]  mem_data_in;
    logic [MEM_WIDTH-1:0]  mem_data_out;

    modport master (
        output mem_wr_en,
        output mem_addr,
        output mem_data_in,
        input  mem_data_out
    );

    modport slave (
        input  mem_wr_en,
        input  mem_addr,
        input  mem_data_in,
        output mem_data_out
    );
endinterface

// File: rtl/mem_bist.sv
// March C- BIST controller for a single-port synchronous memory with registered read data.
// Define MEM_BIST_FAIL_INFO_EN to capture address/expected/actual data of the first mismatch.
module mem_bist #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MEM_DEPTH  = 8,
    parameter int unsigned MEM_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    mem_bist_if.master            mem,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [MEM_WIDTH-1:0]  fail_exp,
    output logic [MEM_WIDTH-1:0]  fail_act
);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [MEM_WIDTH-1:0]  Ones     = {MEM_WIDTH{1'b1}};

    state_e                state_q;
    logic [2:0]            elem_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  phase_q;    // 0: read slot, 1: write slot of an r/w element
    logic                  wr_en_q;
    logic [MEM_WIDTH-1:0]  wdata_q;
    logic                  cmp_pend_q;
    logic [MEM_WIDTH-1:0]  exp_q;

    logic                  is_rd_cur;
    logic [MEM_WIDTH-1:0]  exp_cur;
    logic [2:0]            n_elem;
    logic [ADDR_WIDTH-1:0] n_addr;
    logic                  n_phase;
    logic                  n_wr;
    logic [MEM_WIDTH-1:0]  n_wdata;
    logic                  run_end;
    logic                  mismatch;

    assign mem.mem_wr_en   = wr_en_q;
    assign mem.mem_addr    = addr_q;
    assign mem.mem_data_in = wdata_q;

    assign mismatch = cmp_pend_q && (mem.mem_data_out != exp_q);

    always_comb begin
        logic two_cyc;
        logic down;
        logic at_end;
        two_cyc   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
        down      = (elem_q == 3'd3) || (elem_q == 3'd4);
        at_end    = down ? (addr_q == '0) : (addr_q == LastAddr);
        is_rd_cur = (elem_q == 3'd5) || (two_cyc && !phase_q);
        exp_cur   = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? Ones : '0;

        n_elem  = elem_q;
        n_addr  = addr_q;
        n_phase = 1'b0;
        run_end = 1'b0;
        if (two_cyc && !phase_q) begin
            n_phase = 1'b1;
        end else if (at_end) begin
            if (elem_q == 3'd5) begin
                run_end = 1'b1;
            end else begin
                n_elem = elem_q + 3'd1;
                // M3 and M4 walk downwards
                n_addr = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? LastAddr : '0;
            end
        end else begin
            n_addr = down ? addr_q - 1'b1 : addr_q + 1'b1;
        end

        n_wr    = !((n_elem == 3'd5) || ((n_elem >= 3'd1) && (n_elem <= 3'd4) && !n_phase));
        n_wdata = ((n_elem == 3'd1) || (n_elem == 3'd3)) ? Ones : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            elem_q     <= '0;
            addr_q     <= '0;
            phase_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            wdata_q    <= '0;
            cmp_pend_q <= 1'b0;
            exp_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StRun;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        fail       <= 1'b0;
                        elem_q     <= '0;
                        addr_q     <= '0;
                        phase_q    <= 1'b0;
                        wr_en_q    <= 1'b1;
                        wdata_q    <= '0;
                        cmp_pend_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (mismatch) fail <= 1'b1;
                    cmp_pend_q <= is_rd_cur;
                    exp_q      <= exp_cur;
                    if (run_end) begin
                        state_q <= StFlush;
                        wr_en_q <= 1'b0;
                        addr_q  <= '0;
                        wdata_q <= '0;
                    end else begin
                        elem_q  <= n_elem;
                        addr_q  <= n_addr;
                        phase_q <= n_phase;
                        wr_en_q <= n_wr;
                        wdata_q <= n_wdata;
                    end
                end
                StFlush: begin
                    if (mismatch) fail <= 1'b1;
                    cmp_pend_q <= 1'b0;
                    state_q    <= StDone;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MEM_BIST_FAIL_INFO_EN
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [ADDR_WIDTH-1:0] fail_addr_q;
    logic [MEM_WIDTH-1:0]  fail_exp_q;
    logic [MEM_WIDTH-1:0]  fail_act_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q   <= '0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
        end else begin
            if (state_q == StRun) rd_addr_q <= addr_q;
            if (((state_q == StIdle) || (state_q == StDone)) && start) begin
                fail_addr_q <= '0;
                fail_exp_q  <= '0;
                fail_act_q  <= '0;
            end else if (mismatch && !fail) begin
                fail_addr_q <= rd_addr_q;
                fail_exp_q  <= exp_q;
                fail_act_q  <= mem.mem_data_out;
            end
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;
`else
    assign fail_addr = '0;
    assign fail_exp  = '0;
    assign fail_act  = '0;
`endif

endmodule
